// File: rtl/mv_out_scheduler.sv
// Collects MV rows from NREQ engines in any order and issues them to the
// 64-bit row serializer strictly in row order, one row per BEATS+1 cycles.
//
// state  | meaning
// S_IDLE | no frame active, requests refused
// S_WAIT | waiting for row next_row to be buffered or to arrive
// S_GAP  | row issued; serializer shifting out its beats
module mv_out_scheduler #(
  parameter int NREQ     = 2,
  parameter int NUM_ROWS = 6,
  parameter int ROW_W    = 64,
  parameter int BEATS    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*3-1:0]       req_row,
  input  logic [NREQ*ROW_W-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    ser_valid_o,
  output logic [ROW_W-1:0]        ser_mv_o,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err
);

  localparam int         PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int         CNT_W    = $clog2(BEATS + 1);
  localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

  state_t              r_state, w_state_nxt;
  logic [ROW_W-1:0]    r_slot_data [NUM_ROWS];
  logic [NUM_ROWS-1:0] r_slot_valid;
  logic [NUM_ROWS-1:0] r_issued;
  logic [2:0]          r_next_row;
  logic [CNT_W-1:0]    r_gap_cnt;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic                r_ser_valid;
  logic [ROW_W-1:0]    r_ser_mv;
  logic                r_frame_done;
  logic                r_err;

  logic                w_found;
  logic [PTR_W-1:0]    w_win;
  logic [NREQ-1:0]     w_grant;
  logic [2:0]          w_acc_row;
  logic [2:0]          w_row_idx;
  logic [ROW_W-1:0]    w_acc_data;
  logic                w_row_ok;
  logic                w_legal;
  logic                w_last;
  logic                w_adv;
  logic                w_try;
  logic                w_bypass;
  logic                w_issue;
  logic [2:0]          w_cand;
  logic [ROW_W-1:0]    w_issue_data;

  // Round-robin search starting at the pointer; nothing granted in IDLE.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    if (r_state != S_IDLE) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
          w_found = 1'b1;
          w_win   = PTR_W'((int'(r_rr_ptr) + k) % NREQ);
        end
      end
    end
  end

  always_comb begin
    w_grant        = '0;
    w_grant[w_win] = w_found;
  end

  assign req_ready  = w_grant;
  assign w_acc_row  = req_row[int'(w_win)*3 +: 3];
  assign w_acc_data = req_data[int'(w_win)*ROW_W +: ROW_W];
  assign w_row_ok   = (int'(w_acc_row) < NUM_ROWS);
  assign w_row_idx  = w_row_ok ? w_acc_row : 3'd0;
  assign w_legal    = w_found && w_row_ok && !r_slot_valid[w_row_idx] && !r_issued[w_row_idx];

  // On the last GAP cycle the following row is tried directly, which keeps
  // back-to-back issues exactly BEATS+1 cycles apart.
  assign w_last       = (r_next_row == LAST_ROW);
  assign w_adv        = (r_state == S_GAP) && (r_gap_cnt == '0) && !w_last;
  assign w_cand       = w_adv ? r_next_row + 3'd1 : r_next_row;
  assign w_try        = (r_state == S_WAIT) || w_adv;
  assign w_bypass     = w_try && w_legal && (w_acc_row == w_cand);
  assign w_issue      = w_try && (r_slot_valid[w_cand] || w_bypass);
  assign w_issue_data = r_slot_valid[w_cand] ? r_slot_data[w_cand] : w_acc_data;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_WAIT;
      S_WAIT: if (w_issue) w_state_nxt = S_GAP;
      S_GAP: begin
        if (r_gap_cnt == '0) begin
          if (w_last)        w_state_nxt = S_IDLE;
          else if (!w_issue) w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_slot_valid <= '0;
      r_issued     <= '0;
      r_next_row   <= '0;
      r_gap_cnt    <= '0;
      r_rr_ptr     <= '0;
      r_ser_valid  <= 1'b0;
      r_ser_mv     <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) r_slot_data[i] <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ser_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= w_found && !w_legal;
      if (w_found) r_rr_ptr <= (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
      if (w_legal && !w_bypass) begin
        r_slot_data[w_row_idx]  <= w_acc_data;
        r_slot_valid[w_row_idx] <= 1'b1;
      end
      if (r_state == S_IDLE && start) begin
        r_slot_valid <= '0;
        r_issued     <= '0;
        r_next_row   <= '0;
        r_gap_cnt    <= '0;
      end
      if (w_issue) begin
        r_ser_valid          <= 1'b1;
        r_ser_mv             <= w_issue_data;
        r_issued[w_cand]     <= 1'b1;
        r_slot_valid[w_cand] <= 1'b0;
        r_next_row           <= w_cand;
        r_gap_cnt            <= CNT_W'(BEATS);
      end else if (r_state == S_GAP) begin
        if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
        else if (w_last)     r_frame_done <= 1'b1;
        else                 r_next_row <= w_cand;
      end
    end
  end

  assign ser_valid_o = r_ser_valid;
  assign ser_mv_o    = r_ser_mv;
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = r_frame_done;
  assign err         = r_err;

endmodule

// File: tb/tb_mv_out_scheduler.sv
// Directed bench for mv_out_scheduler: in-order, out-of-order, dual-requester,
// error, restart/reset and idle-wait scenarios.
module tb_mv_out_scheduler;
  localparam int NREQ  = 2;
  localparam int ROW_W = 64;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*3-1:0]     req_row;
  logic [NREQ*ROW_W-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  ser_valid_o;
  logic [ROW_W-1:0]      ser_mv_o;
  logic                  busy;
  logic                  frame_done;
  logic                  err;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int p_cyc[$];
  logic [63:0] p_dat[$];
  int e_cyc[$];
  int acc_cyc[$];
  int acc_rq[$];
  int fd_cnt = 0;
  int fd_cyc = 0;
  logic busy_fd = 1'b1;

  mv_out_scheduler #(.NREQ(2), .NUM_ROWS(6), .ROW_W(64), .BEATS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(req_valid), .req_row(req_row), .req_data(req_data),
    .req_ready(req_ready), .ser_valid_o(ser_valid_o), .ser_mv_o(ser_mv_o),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ser_valid_o) begin
      p_cyc.push_back(cyc);
      p_dat.push_back(ser_mv_o);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc  = cyc;
      busy_fd = busy;
    end
    if (err) e_cyc.push_back(cyc);
  end

  function automatic logic [63:0] mvd(input int r);
    return 64'h0101010101010101 * 64'(r + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    p_cyc.delete(); p_dat.delete(); e_cyc.delete();
    acc_cyc.delete(); acc_rq.delete();
    fd_cnt = 0; fd_cyc = 0; busy_fd = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send(input int rq, input int row, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    req_valid[rq] = 1'b1;
    req_row[rq*3 +: 3] = 3'(row);
    req_data[rq*ROW_W +: ROW_W] = d;
    #1;
    while (!req_ready[rq] && n < 60) begin
      @(negedge clk); #1; n++;
    end
    chk($sformatf("grant_r%0d_row%0d", rq, row), req_ready[rq], 1);
    acc_cyc.push_back(cyc);
    acc_rq.push_back(rq);
    @(posedge clk);
    #1 req_valid[rq] = 1'b0;
  endtask

  task automatic wait_frame(input string t);
    int n;
    n = 0;
    while (fd_cnt == 0 && n < 400) begin
      @(negedge clk); #1; n++;
    end
    chk({t, "_done"}, fd_cnt, 1);
  endtask

  task automatic wait_pulses(input string t, input int k);
    int n;
    n = 0;
    while (p_cyc.size() < k && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk({t, "_npulse"}, p_cyc.size(), k);
  endtask

  task automatic check_frame(input string t);
    chk({t, "_npulse"}, p_cyc.size(), 6);
    for (int i = 0; i < 6 && i < p_cyc.size(); i++) begin
      chk($sformatf("%s_data%0d", t, i), p_dat[i], mvd(i));
      if (i > 0) chk($sformatf("%s_gap%0d", t, i), p_cyc[i] - p_cyc[i-1], 9);
    end
    if (p_cyc.size() > 0) chk({t, "_fd_cyc"}, fd_cyc, p_cyc[p_cyc.size()-1] + 9);
    chk({t, "_busy_at_fd"}, busy_fd, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; req_valid = '0; req_row = '0; req_data = '0;
    repeat (3) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_ser_valid", ser_valid_o, 0);
    chk("rst_ser_mv", ser_mv_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = '0;
    rst_n = 1'b1;

    // start and a row-0 request together in IDLE: the request must be refused
    @(negedge clk);
    req_valid = 2'b01; req_row = '0; req_data[63:0] = mvd(0); start = 1'b1;
    #1 chk("idle_ready", req_ready, 0);
    @(posedge clk);
    #1 begin start = 1'b0; req_valid = '0; end
    repeat (12) @(negedge clk);
    #1 chk("idle_noaccept", p_cyc.size(), 0);
    chk("idle_busy", busy, 1);

    // 1: in-order rows from requester 0
    do_reset();
    do_start();
    chk("t1_busy_on", busy, 1);
    for (int r = 0; r < 6; r++) send(0, r, mvd(r));
    wait_frame("t1");
    if (p_cyc.size() > 0) chk("t1_latency", p_cyc[0], acc_cyc[0] + 1);
    check_frame("t1");
    chk("t1_err", e_cyc.size(), 0);

    // 2: out-of-order rows from requester 1
    do_reset();
    do_start();
    send(1, 3, mvd(3)); send(1, 5, mvd(5)); send(1, 4, mvd(4));
    send(1, 2, mvd(2)); send(1, 1, mvd(1));
    repeat (3) @(negedge clk);
    #1 chk("t2_hold", p_cyc.size(), 0);
    send(1, 0, mvd(0));
    wait_frame("t2");
    if (p_cyc.size() > 0) chk("t2_latency", p_cyc[0], acc_cyc[5] + 1);
    check_frame("t2");

    // 3: both requesters continuously valid
    do_reset();
    do_start();
    fork
      begin send(0, 0, mvd(0)); send(0, 2, mvd(2)); send(0, 4, mvd(4)); end
      begin send(1, 1, mvd(1)); send(1, 3, mvd(3)); send(1, 5, mvd(5)); end
    join
    for (int i = 0; i < 6 && i < acc_cyc.size(); i++) begin
      chk($sformatf("t3_rq%0d", i), acc_rq[i], i % 2);
      chk($sformatf("t3_acc%0d", i), acc_cyc[i], acc_cyc[0] + i);
    end
    wait_frame("t3");
    check_frame("t3");

    // 4: duplicate, re-send after issue, out-of-range row
    do_reset();
    do_start();
    send(0, 1, mvd(1));
    send(0, 2, mvd(2));
    send(0, 2, 64'hDEAD_BEEF_0000_0002);
    send(0, 7, 64'hDEAD_BEEF_0000_0007);
    send(0, 0, mvd(0));
    wait_pulses("t4_first", 1);
    send(0, 0, 64'hDEAD_BEEF_0000_0000);
    send(0, 3, mvd(3)); send(0, 4, mvd(4)); send(0, 5, mvd(5));
    wait_frame("t4");
    check_frame("t4");
    chk("t4_err_cnt", e_cyc.size(), 3);
    if (e_cyc.size() > 0) chk("t4_err_timing", e_cyc[0], acc_cyc[2] + 1);

    // 5a: start mid-frame is ignored
    do_reset();
    do_start();
    send(0, 0, mvd(0)); send(0, 1, mvd(1)); send(0, 2, mvd(2));
    do_start();
    send(0, 3, mvd(3)); send(0, 4, mvd(4)); send(0, 5, mvd(5));
    wait_frame("t5a");
    check_frame("t5a");
    repeat (20) @(negedge clk);
    #1 chk("t5a_one_frame", fd_cnt, 1);
    chk("t5a_idle", busy, 0);

    // 5b: asynchronous reset during GAP of row 3, then a fresh frame
    do_reset();
    do_start();
    for (int r = 0; r < 6; r++) send(0, r, mvd(r));
    wait_pulses("t5b_pre", 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5b_rst_mv", ser_mv_o, 0);
    chk("t5b_rst_busy", busy, 0);
    chk("t5b_rst_valid", ser_valid_o, 0);
    chk("t5b_rst_done", frame_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    do_start();
    send(0, 1, mvd(1) ^ 64'hF0F0);
    repeat (12) @(negedge clk);
    #1 chk("t5b_wait_row0", p_cyc.size(), 0);
    send(0, 0, mvd(0) ^ 64'hF0F0);
    @(negedge clk);
    #1 chk("t5b_restart_pulse", p_cyc.size(), 1);
    if (p_cyc.size() > 0) begin
      chk("t5b_restart_lat", p_cyc[0], acc_cyc[1] + 1);
      chk("t5b_restart_data", p_dat[0], mvd(0) ^ 64'hF0F0);
    end
    repeat (30) @(negedge clk);
    #1 chk("t5b_no_stale", p_cyc.size(), 2);
    if (p_cyc.size() > 1) chk("t5b_row1_data", p_dat[1], mvd(1) ^ 64'hF0F0);

    // 6: long wait with no requests
    do_reset();
    do_start();
    repeat (50) @(negedge clk);
    #1;
    chk("t6_busy", busy, 1);
    chk("t6_no_pulse", p_cyc.size(), 0);
    chk("t6_no_err", e_cyc.size(), 0);
    send(1, 0, mvd(0));
    @(negedge clk);
    #1 chk("t6_pulse", p_cyc.size(), 1);
    if (p_cyc.size() > 0) chk("t6_latency", p_cyc[0], acc_cyc[0] + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
